// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage byte-serial memory sequencer.
// Encodings match the control unit: WORD/BYTE for mem_size, STORE/LOAD for mem_rw.
// The request struct is the copy of EX_MEM held stable while a transfer runs.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic WORD  = 1'b1;
  localparam logic BYTE  = 1'b0;
  localparam logic STORE = 1'b1;
  localparam logic LOAD  = 1'b0;

  localparam int unsigned DEF_WORD_BYTES = 4;

  // Beat counter width; a single-byte "word" still needs one bit of counter.
  function automatic int unsigned beat_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BEAT_W = beat_width(DEF_WORD_BYTES);

  typedef struct packed {
    logic        rw;
    logic        size;
    logic        load_instr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_sel.sv
// Byte-lane steering: picks the store byte for a beat and merges a loaded byte into the word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module mem_lane_sel
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
  parameter int unsigned BW         = BEAT_W,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic          size,
  input  logic [BW-1:0] beat,
  input  logic [31:0]   wdata,
  input  logic [7:0]    rdata,
  input  logic [31:0]   acc,
  output logic [7:0]    wr_byte,
  output logic [31:0]   acc_next,
  output logic [31:0]   ld_result
);

  logic [4:0] shamt;

  // Byte accesses always live in the low lane; word beats map to lanes by endianness.
  always_comb begin
    shamt = '0;
    if (size == WORD) begin
      if (BIG_ENDIAN)
        shamt = 5'(8 * (int'(WORD_BYTES) - 1 - int'(beat)));
      else
        shamt = 5'(8 * int'(beat));
    end
    wr_byte   = 8'(wdata >> shamt);
    acc_next  = (acc & ~(32'h0000_00FF << shamt)) | ({24'b0, rdata} << shamt);
    ld_result = (size == WORD) ? acc : {24'b0, acc[7:0]};
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: turns one byte/word load or store into byte-serial RAM beats.
// Latency: word 5 stalled cycles + result cycle; byte 2 + result; non-memory ops 0.
// Backpressure: stall freezes upstream pipeline registers until the DONE cycle.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              R,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic              mem_load_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [31:0]       alu_result,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              stall,
  output logic [31:0]       wb_data,
  output logic              wb_valid
);

  localparam int unsigned BW = beat_width(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [BW-1:0]     LAST_WORD  = BW'(WORD_BYTES - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  req_t              req_q, req_d;
  logic [31:0]       acc_q, acc_d;
  logic              ram_we_raw;
  logic [BW-1:0]     last_beat;

  logic [7:0]        wr_byte;
  logic [31:0]       acc_next;
  logic [31:0]       ld_result;

  mem_lane_sel #(
    .WORD_BYTES (WORD_BYTES),
    .BW         (BW),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_sel (
    .size      (req_q.size),
    .beat      (beat_q),
    .wdata     (req_q.wdata),
    .rdata     (ram_rdata),
    .acc       (acc_q),
    .wr_byte   (wr_byte),
    .acc_next  (acc_next),
    .ld_result (ld_result)
  );

  assign last_beat = (req_q.size == WORD) ? LAST_WORD : '0;

  // A reset arriving mid-store must not let the current byte land in RAM.
  assign ram_we = ram_we_raw & ~R;

  // State register plus the latched request, base address, beat and load accumulator.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      req_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      req_q   <= req_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state and output decode; request is only sampled in IDLE.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    req_d      = req_q;
    acc_d      = acc_q;
    stall      = 1'b0;
    wb_valid   = 1'b1;
    wb_data    = alu_result;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_enable) begin
          stall    = 1'b1;
          wb_valid = 1'b0;
          req_d    = '{rw: mem_rw, size: mem_size, load_instr: mem_load_instr, wdata: mem_wdata};
          // Word accesses silently drop misaligned low address bits.
          base_d   = (mem_size == WORD) ? (mem_addr & ALIGN_MASK) : mem_addr;
          beat_d   = '0;
          acc_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        wb_valid = 1'b0;
        ram_addr = base_q + ADDR_W'(beat_q);
        if (req_q.rw == STORE) begin
          ram_we_raw = 1'b1;
          ram_wdata  = wr_byte;
        end else if (req_q.rw == LOAD) begin
          acc_d = acc_next;
        end
        if (beat_q == last_beat)
          state_d = DONE;
        else
          beat_d = beat_q + 1'b1;
      end
      DONE: begin
        if (req_q.load_instr)
          wb_data = ld_result;
        // EX_MEM advances at the end of this cycle, so never re-sample here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench: driver pushes expected writeback/latency/RAM writes, monitor pops and compares.
// Reference model is a golden byte array updated by plain endian arithmetic per instruction.
// A behavioural RAM sits on the DUT's byte port; its final image is compared to the model.
module tb_mem_stage_ctrl;

  localparam bit BIG_ENDIAN = 1'b1;

  logic        clk;
  logic        R;
  logic        mem_enable;
  logic        mem_rw;
  logic        mem_size;
  logic        mem_load_instr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] alu_result;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        stall;
  logic [31:0] wb_data;
  logic        wb_valid;

  mem_stage_ctrl #(
    .ADDR_W     (8),
    .WORD_BYTES (4),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) dut (
    .clk            (clk),
    .R              (R),
    .mem_enable     (mem_enable),
    .mem_rw         (mem_rw),
    .mem_size       (mem_size),
    .mem_load_instr (mem_load_instr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .alu_result     (alu_result),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .stall          (stall),
    .wb_data        (wb_data),
    .wb_valid       (wb_valid)
  );

  typedef struct {
    logic [31:0] wb;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t       eq[$];
  wr_t        wq[$];
  logic [7:0] mem  [256];
  logic [7:0] pre  [256];
  logic [7:0] gold [256];
  logic       preload;
  logic       mon_on;
  int         stall_cnt;
  int         total;
  int         bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= pre[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (mon_on) begin
      if (ram_we) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %h data %h want none", ram_addr, ram_wdata);
        end else begin
          w = wq.pop_front();
          chk("write_addr", {24'b0, ram_addr}, {24'b0, w.a});
          chk("write_data", {24'b0, ram_wdata}, {24'b0, w.d});
        end
      end
      if (stall) begin
        stall_cnt++;
        chk("wb_valid_in_stall", {31'b0, wb_valid}, 32'd0);
      end else begin
        if (eq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL no_expectation: got wb_data %h want none", wb_data);
        end else begin
          e = eq.pop_front();
          chk("wb_data", wb_data, e.wb);
          chk("wb_valid", {31'b0, wb_valid}, 32'd1);
          chk("stall_cycles", stall_cnt, e.stalls);
        end
        stall_cnt = 0;
      end
    end
  end

  // Present one instruction from EX_MEM and hold it until the DUT releases stall.
  task automatic issue(input bit en, input bit rw, input bit sz, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] alu);
    exp_t        e;
    wr_t         w;
    logic [7:0]  base;
    logic [31:0] wv;
    int          lane;
    int          n;
    bit          fin;
    mem_enable     = en;
    mem_rw         = rw;
    mem_size       = sz;
    mem_load_instr = en && !rw;
    mem_addr       = a;
    mem_wdata      = wd;
    alu_result     = alu;
    e.wb     = alu;
    e.stalls = 0;
    if (en && sz) begin
      base     = a & 8'hFC;
      e.stalls = 5;
      wv       = '0;
      for (int i = 0; i < 4; i++) begin
        lane = BIG_ENDIAN ? 3 - i : i;
        w.a  = 8'(base + i);
        if (rw) begin
          w.d       = wd[8*lane +: 8];
          gold[w.a] = w.d;
          wq.push_back(w);
        end else begin
          wv[8*lane +: 8] = gold[w.a];
        end
      end
      if (!rw) e.wb = wv;
    end else if (en) begin
      e.stalls = 2;
      if (rw) begin
        w.a     = a;
        w.d     = wd[7:0];
        gold[a] = w.d;
        wq.push_back(w);
      end else begin
        e.wb = {24'b0, gold[a]};
      end
    end
    eq.push_back(e);
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      fin = !stall;
      @(posedge clk);
      #1;
      n++;
      if (!fin && n >= 16) begin
        total++;
        bad++;
        $display("FAIL stall_timeout: got stall after %0d cycles want release", n);
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int diffs;
    total = 0;
    bad = 0;
    stall_cnt = 0;
    mon_on = 1'b0;
    for (int i = 0; i < 256; i++) pre[i] = 8'($urandom);
    pre[52] = 8'h11; pre[53] = 8'h22; pre[54] = 8'h33; pre[55] = 8'h44;
    pre[56] = 8'h9A;
    for (int i = 0; i < 256; i++) gold[i] = pre[i];
    preload = 1'b1;
    R = 1'b1;
    mem_enable = 1'b0; mem_rw = 1'b0; mem_size = 1'b0; mem_load_instr = 1'b0;
    mem_addr = '0; mem_wdata = '0; alu_result = 32'h1357_2468;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    R = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("rst_wb_data", wb_data, 32'h1357_2468);
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    issue(0, 0, 0, 8'h10, 32'h0, 32'hA5A5_0001);
    issue(1, 0, 1, 8'd52, 32'h0, 32'hFFFF_0002);
    issue(1, 0, 0, 8'd56, 32'h0, 32'hFFFF_0003);
    issue(1, 1, 1, 8'd60, 32'hDEAD_BEEF, 32'h0BAD_0004);
    issue(1, 0, 1, 8'd60, 32'h0, 32'hFFFF_0005);
    issue(1, 0, 1, 8'h35, 32'h0, 32'hFFFF_0006);
    issue(1, 1, 0, 8'd58, 32'h1234_56A5, 32'h0BAD_0007);
    issue(1, 0, 0, 8'd58, 32'h0, 32'hFFFF_0008);
    issue(0, 0, 0, 8'h00, 32'h0, 32'h7777_0009);
    issue(1, 0, 0, 8'd59, 32'h0, 32'hFFFF_000A);
    issue(1, 0, 0, 8'd57, 32'h0, 32'hFFFF_000B);

    // Reset during beat 2 of a word store to 64: only bytes 64 and 65 may land.
    mon_on = 1'b0;
    mem_enable = 1'b1; mem_rw = 1'b1; mem_size = 1'b1; mem_load_instr = 1'b0;
    mem_addr = 8'd64; mem_wdata = 32'hCAFE_F00D; alu_result = 32'h2468_ACE0;
    @(posedge clk); #1;
    mem_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    R = 1'b1;
    @(negedge clk);
    chk("rst_gates_we", {31'b0, ram_we}, 32'd0);
    @(posedge clk); #1;
    R = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    chk("post_rst_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("post_rst_wb_data", wb_data, 32'h2468_ACE0);
    chk("ram64", {24'b0, mem[64]}, 32'h0000_00CA);
    chk("ram65", {24'b0, mem[65]}, 32'h0000_00FE);
    chk("ram66", {24'b0, mem[66]}, {24'b0, gold[66]});
    chk("ram67", {24'b0, mem[67]}, {24'b0, gold[67]});
    gold[64] = 8'hCA;
    gold[65] = 8'hFE;
    @(posedge clk); #1;
    stall_cnt = 0;
    mon_on = 1'b1;
    issue(1, 0, 0, 8'd65, 32'h0, 32'hFFFF_000C);
    issue(1, 0, 1, 8'd66, 32'h0, 32'hFFFF_000D);

    for (int k = 0; k < 300; k++) begin
      issue($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), $urandom, $urandom);
    end

    mon_on = 1'b0;
    chk("exp_queue_empty", eq.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) diffs++;
    chk("ram_image_diffs", diffs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
